fpu_arbiter: RTL and testbench
==============================

FPU_ARBITER -- requirements
Module: fpu_arbiter

Interface
REQ-001 The module SHALL have the port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 The module SHALL have the port rst, input, 1 bit: the reset, which is synchronous and active-high.
REQ-003 The module SHALL have the ports req0_order and req1_order, input, 1 bit each: requester N asks for one FPU operation.
REQ-004 The module SHALL have the ports req0_rs1, req0_rs2, req1_rs1 and req1_rs2, input, 32 bits each: operands for requester N, held stable while reqN_order=1.
REQ-005 The module SHALL have the ports req0_func3 and req1_func3, input, 3 bits each: operation select for requester N.
REQ-006 The module SHALL have the ports req0_accepted and req1_accepted, output, 1 bit each: a one-cycle pulse meaning requester N's operands have been latched.
REQ-007 The module SHALL have the ports req0_done and req1_done, output, 1 bit each: a one-cycle pulse meaning the result is valid on reqN_rd.
REQ-008 The module SHALL have the ports req0_rd and req1_rd, output, 32 bits each: the captured result.
REQ-009 The module SHALL have the ports fpu_order (output, 1 bit), fpu_accepted (input, 1 bit) and fpu_done (input, 1 bit): the shared-FPU handshake.
REQ-010 The module SHALL have the ports fpu_rs1 and fpu_rs2 (output, 32 bits each), fpu_func3 (output, 3 bits) and fpu_rd (input, 32 bits): the shared-FPU operands and result.

Function
REQ-011 The module SHALL serialize the two requesters onto one FPU and keep at most one operation in flight.
REQ-012 The state machine SHALL have the states IDLE, ISSUE, WAIT and RESP; all outputs SHALL be registered.
REQ-013 In IDLE, when any reqN_order=1, the module SHALL latch the granted requester's rs1, rs2 and func3 into operand registers, pulse reqN_accepted in the next cycle, and go to ISSUE.
REQ-014 When only one requester orders, that requester SHALL be granted.
REQ-015 When both requesters order, the requester selected by the 1-bit priority pointer prio SHALL be granted, and prio SHALL then be set to the other port.
REQ-016 When a single requester is granted, prio SHALL be set to the non-granted port.
REQ-017 A requester that is not granted SHALL receive no accepted pulse and SHALL keep its order asserted; the module SHALL service it at the next IDLE.
REQ-018 In ISSUE, fpu_order SHALL be 1, with fpu_rs1, fpu_rs2 and fpu_func3 driven from the operand registers.
REQ-019 In ISSUE, if fpu_accepted=1 and fpu_done=1 in the same cycle, the module SHALL capture fpu_rd and go to RESP.
REQ-020 In ISSUE, if fpu_accepted=1 and fpu_done=0, the module SHALL go to WAIT.
REQ-021 In ISSUE, if fpu_accepted=0, the module SHALL stay in ISSUE, holding fpu_order and the operands.
REQ-022 In WAIT, fpu_order SHALL be 0; on fpu_done=1 the module SHALL capture fpu_rd and go to RESP.
REQ-023 In RESP, the granted reqN_done SHALL be 1 for exactly one cycle, and the module SHALL then go to IDLE.
REQ-024 A new grant SHALL NOT occur in RESP.
REQ-025 reqN_rd SHALL both present the single captured-result register, and that register SHALL change only on capture.
REQ-026 reqN_rd SHALL be meaningful only alongside reqN_done.
REQ-027 Minimum latency against a same-cycle FPU SHALL be: order at cycle 0, accepted and ISSUE at cycle 1, done at cycle 2.
REQ-028 A requester reordering in the cycle its done is asserted SHALL be eligible in the following IDLE cycle.
REQ-029 fpu_accepted and fpu_done SHALL be ignored in IDLE and RESP, and fpu_accepted SHALL be ignored in WAIT.
REQ-030 The accepted and done pulses SHALL only ever be asserted for the granted port, and never for both ports in the same cycle.

Reset
REQ-031 When rst=1 at a clock edge, the module SHALL enter IDLE with prio=0, and all outputs SHALL be 0: fpu_order, reqN_accepted, reqN_done, reqN_rd, fpu_rs1, fpu_rs2 and fpu_func3.
REQ-032 A reset mid-operation (ISSUE, WAIT or RESP) SHALL abandon the in-flight operation with no done pulse, and a late fpu_done arriving after reset SHALL be ignored.
REQ-033 While rst=1, orders SHALL be ignored, and the first grant SHALL be possible in the first cycle after rst deasserts.

Verification
REQ-034 The bench SHALL drive req0 with rs1=0x3F800000 and rs2=0x40000000, func3=001, against an FPU that accepts and finishes in the same cycle, and check req0_accepted at cycle 1, then req0_done with req0_rd=0x00000001 at cycle 2.
REQ-035 The bench SHALL assert both orders at the same time from reset, and check req0 is served first, req1's accepted arrives after req0_done, and req1_rd is correct.
REQ-036 The bench SHALL keep both requesters continuously ordering for 6 operations, and check grants alternate 0,1,0,1,0,1.
REQ-037 The bench SHALL hold fpu_accepted=0 for 3 cycles and then assert fpu_done 4 cycles after accept, and check fpu_order stays high 4 cycles with stable operands, stays low in WAIT, and gives a single done pulse.
REQ-038 The bench SHALL assert rst for 1 cycle while in WAIT, then assert fpu_done, and check there is no reqN_done, the state is IDLE, and all outputs are 0.
REQ-039 The bench SHALL change req1 operands after req1_accepted and before done, and check the FPU still sees the latched values.

Source files
------------

// File: rtl/fpu_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : fpu_arbiter
// Description : Two-port arbiter that serializes requesters onto one shared
//               FPU, one operation in flight, round-robin on contention.
// Revision    : 1.0 - initial release
// ============================================================================
module fpu_arbiter (
    input  logic        clk,
    input  logic        rst,
    // requester 0
    input  logic        req0_order,
    input  logic [31:0] req0_rs1,
    input  logic [31:0] req0_rs2,
    input  logic [2:0]  req0_func3,
    output logic        req0_accepted,
    output logic        req0_done,
    output logic [31:0] req0_rd,
    // requester 1
    input  logic        req1_order,
    input  logic [31:0] req1_rs1,
    input  logic [31:0] req1_rs2,
    input  logic [2:0]  req1_func3,
    output logic        req1_accepted,
    output logic        req1_done,
    output logic [31:0] req1_rd,
    // shared FPU
    output logic        fpu_order,
    input  logic        fpu_accepted,
    input  logic        fpu_done,
    output logic [31:0] fpu_rs1,
    output logic [31:0] fpu_rs2,
    output logic [2:0]  fpu_func3,
    input  logic [31:0] fpu_rd
);

    typedef enum logic [1:0] {
        c_IDLE  = 2'd0,
        c_ISSUE = 2'd1,
        c_WAIT  = 2'd2,
        c_RESP  = 2'd3
    } state_t;

    state_t      r_state;
    logic        r_prio;      // port that wins when both order
    logic        r_gnt;       // port owning the in-flight operation
    logic [31:0] r_rs1;
    logic [31:0] r_rs2;
    logic [2:0]  r_func3;
    logic [31:0] r_result;    // single result register shared by both ports
    logic        r_fpu_order;
    logic        r_acc0;
    logic        r_acc1;
    logic        r_done0;
    logic        r_done1;

    state_t      w_state;
    logic        w_prio;
    logic        w_gnt;
    logic        w_sel;
    logic [31:0] w_rs1;
    logic [31:0] w_rs2;
    logic [2:0]  w_func3;
    logic [31:0] w_result;
    logic        w_fpu_order;
    logic        w_acc0;
    logic        w_acc1;
    logic        w_done0;
    logic        w_done1;

    // With both ordering the pointer decides; otherwise the lone orderer wins.
    assign w_sel = (req0_order && req1_order) ? r_prio : req1_order;

    // Next-state and next-output logic; every output is registered below.
    always_comb begin
        w_state     = r_state;
        w_prio      = r_prio;
        w_gnt       = r_gnt;
        w_rs1       = r_rs1;
        w_rs2       = r_rs2;
        w_func3     = r_func3;
        w_result    = r_result;
        w_fpu_order = 1'b0;
        w_acc0      = 1'b0;
        w_acc1      = 1'b0;
        w_done0     = 1'b0;
        w_done1     = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (req0_order || req1_order) begin
                    w_gnt       = w_sel;
                    w_prio      = ~w_sel;
                    w_rs1       = w_sel ? req1_rs1   : req0_rs1;
                    w_rs2       = w_sel ? req1_rs2   : req0_rs2;
                    w_func3     = w_sel ? req1_func3 : req0_func3;
                    w_acc0      = ~w_sel;
                    w_acc1      = w_sel;
                    w_fpu_order = 1'b1;
                    w_state     = c_ISSUE;
                end
            end
            c_ISSUE: begin
                if (fpu_accepted) begin
                    if (fpu_done) begin
                        w_result = fpu_rd;
                        w_done0  = ~r_gnt;
                        w_done1  = r_gnt;
                        w_state  = c_RESP;
                    end else begin
                        w_state  = c_WAIT;
                    end
                end else begin
                    // FPU has not taken the order yet: keep offering it
                    w_fpu_order = 1'b1;
                end
            end
            c_WAIT: begin
                if (fpu_done) begin
                    w_result = fpu_rd;
                    w_done0  = ~r_gnt;
                    w_done1  = r_gnt;
                    w_state  = c_RESP;
                end
            end
            c_RESP: begin
                w_state = c_IDLE;
            end
            default: begin
                w_state = c_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_IDLE;
            r_prio      <= 1'b0;
            r_gnt       <= 1'b0;
            r_rs1       <= 32'd0;
            r_rs2       <= 32'd0;
            r_func3     <= 3'd0;
            r_result    <= 32'd0;
            r_fpu_order <= 1'b0;
            r_acc0      <= 1'b0;
            r_acc1      <= 1'b0;
            r_done0     <= 1'b0;
            r_done1     <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_prio      <= w_prio;
            r_gnt       <= w_gnt;
            r_rs1       <= w_rs1;
            r_rs2       <= w_rs2;
            r_func3     <= w_func3;
            r_result    <= w_result;
            r_fpu_order <= w_fpu_order;
            r_acc0      <= w_acc0;
            r_acc1      <= w_acc1;
            r_done0     <= w_done0;
            r_done1     <= w_done1;
        end
    end

    assign req0_accepted = r_acc0;
    assign req1_accepted = r_acc1;
    assign req0_done     = r_done0;
    assign req1_done     = r_done1;
    assign req0_rd       = r_result;
    assign req1_rd       = r_result;
    assign fpu_order     = r_fpu_order;
    assign fpu_rs1       = r_rs1;
    assign fpu_rs2       = r_rs2;
    assign fpu_func3     = r_func3;

endmodule
`default_nettype wire

// File: tb/tb_fpu_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_fpu_arbiter
// Description : Directed self-checking bench for fpu_arbiter with a stub FPU.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fpu_arbiter;

    logic        clk;
    logic        rst;
    logic        req0_order, req1_order;
    logic [31:0] req0_rs1, req0_rs2, req1_rs1, req1_rs2;
    logic [2:0]  req0_func3, req1_func3;
    logic        req0_accepted, req1_accepted;
    logic        req0_done, req1_done;
    logic [31:0] req0_rd, req1_rd;
    logic        fpu_order, fpu_accepted, fpu_done;
    logic [31:0] fpu_rs1, fpu_rs2, fpu_rd;
    logic [2:0]  fpu_func3;

    // Stub FPU: either answers in the same cycle it is ordered, or follows
    // handshake levels driven directly by the stimulus.
    logic        fpu_auto;
    logic        man_acc;
    logic        man_done;

    int tests;
    int fails;

    // func3=001 is a less-than compare (valid for positive floats),
    // anything else returns the integer sum of the operands.
    function automatic logic [31:0] fpu_model(input logic [31:0] a,
                                              input logic [31:0] b,
                                              input logic [2:0]  f);
        if (f == 3'b001) return {31'd0, (a < b)};
        return a + b;
    endfunction

    assign fpu_accepted = fpu_auto ? fpu_order : man_acc;
    assign fpu_done     = fpu_auto ? fpu_order : man_done;
    assign fpu_rd       = fpu_model(fpu_rs1, fpu_rs2, fpu_func3);

    fpu_arbiter dut (
        .clk           (clk),
        .rst           (rst),
        .req0_order    (req0_order),
        .req0_rs1      (req0_rs1),
        .req0_rs2      (req0_rs2),
        .req0_func3    (req0_func3),
        .req0_accepted (req0_accepted),
        .req0_done     (req0_done),
        .req0_rd       (req0_rd),
        .req1_order    (req1_order),
        .req1_rs1      (req1_rs1),
        .req1_rs2      (req1_rs2),
        .req1_func3    (req1_func3),
        .req1_accepted (req1_accepted),
        .req1_done     (req1_done),
        .req1_rd       (req1_rd),
        .fpu_order     (fpu_order),
        .fpu_accepted  (fpu_accepted),
        .fpu_done      (fpu_done),
        .fpu_rs1       (fpu_rs1),
        .fpu_rs2       (fpu_rs2),
        .fpu_func3     (fpu_func3),
        .fpu_rd        (fpu_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".fpu_order"}, {31'd0, fpu_order}, 32'd0);
        check({tag, ".acc0"},      {31'd0, req0_accepted}, 32'd0);
        check({tag, ".acc1"},      {31'd0, req1_accepted}, 32'd0);
        check({tag, ".done0"},     {31'd0, req0_done}, 32'd0);
        check({tag, ".done1"},     {31'd0, req1_done}, 32'd0);
        check({tag, ".rd0"},       req0_rd, 32'd0);
        check({tag, ".rd1"},       req1_rd, 32'd0);
        check({tag, ".fpu_rs1"},   fpu_rs1, 32'd0);
        check({tag, ".fpu_rs2"},   fpu_rs2, 32'd0);
        check({tag, ".fpu_func3"}, {29'd0, fpu_func3}, 32'd0);
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst = 1'b1;
        req0_order = 1'b0; req1_order = 1'b0;
        req0_rs1 = 32'd0; req0_rs2 = 32'd0; req0_func3 = 3'd0;
        req1_rs1 = 32'd0; req1_rs2 = 32'd0; req1_func3 = 3'd0;
        fpu_auto = 1'b1; man_acc = 1'b0; man_done = 1'b0;
        tick();
        tick();

        // ---- reset state, orders ignored while in reset
        check_all_zero("reset");
        req0_order = 1'b1;
        req0_rs1 = 32'h3F800000; req0_rs2 = 32'h40000000; req0_func3 = 3'b001;
        tick();
        check("rst_ignores_order.acc0", {31'd0, req0_accepted}, 32'd0);
        check("rst_ignores_order.fpu_order", {31'd0, fpu_order}, 32'd0);

        // ---- single requester, same-cycle FPU: accepted at 1, done at 2
        rst = 1'b0;
        tick();
        check("lat.acc0", {31'd0, req0_accepted}, 32'd1);
        check("lat.acc1", {31'd0, req1_accepted}, 32'd0);
        check("lat.fpu_order", {31'd0, fpu_order}, 32'd1);
        check("lat.fpu_rs1", fpu_rs1, 32'h3F800000);
        check("lat.fpu_rs2", fpu_rs2, 32'h40000000);
        check("lat.fpu_func3", {29'd0, fpu_func3}, 32'd1);
        check("lat.done0_early", {31'd0, req0_done}, 32'd0);
        req0_order = 1'b0;
        tick();
        check("lat.done0", {31'd0, req0_done}, 32'd1);
        check("lat.rd0", req0_rd, 32'h00000001);
        check("lat.done1", {31'd0, req1_done}, 32'd0);
        check("lat.acc0_pulse", {31'd0, req0_accepted}, 32'd0);
        tick();
        check("lat.done0_pulse", {31'd0, req0_done}, 32'd0);

        // ---- simultaneous orders from reset: port 0 first
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req0_order = 1'b1; req0_rs1 = 32'h10; req0_rs2 = 32'h20; req0_func3 = 3'b000;
        req1_order = 1'b1; req1_rs1 = 32'h40000000; req1_rs2 = 32'h3F800000; req1_func3 = 3'b000;
        tick();
        check("both.acc0", {31'd0, req0_accepted}, 32'd1);
        check("both.acc1", {31'd0, req1_accepted}, 32'd0);
        check("both.fpu_rs1", fpu_rs1, 32'h10);
        req0_order = 1'b0;
        tick();
        check("both.done0", {31'd0, req0_done}, 32'd1);
        check("both.rd0", req0_rd, 32'h30);
        check("both.acc1_during_done0", {31'd0, req1_accepted}, 32'd0);
        tick();
        check("both.acc1_idle", {31'd0, req1_accepted}, 32'd0);
        tick();
        check("both.acc1", {31'd0, req1_accepted}, 32'd1);
        check("both.fpu_rs1_1", fpu_rs1, 32'h40000000);
        req1_order = 1'b0;
        tick();
        check("both.done1", {31'd0, req1_done}, 32'd1);
        check("both.done0_not", {31'd0, req0_done}, 32'd0);
        check("both.rd1", req1_rd, 32'h7F800000);

        // ---- continuous contention: grants alternate 0,1,0,1,0,1
        req0_order = 1'b1; req0_rs1 = 32'd10;  req0_rs2 = 32'd3;   req0_func3 = 3'b000;
        req1_order = 1'b1; req1_rs1 = 32'd100; req1_rs2 = 32'd200; req1_func3 = 3'b000;
        tick();
        for (int i = 0; i < 6; i++) begin
            tick();
            check($sformatf("rr%0d.acc0", i), {31'd0, req0_accepted}, {31'd0, (i % 2 == 0)});
            check($sformatf("rr%0d.acc1", i), {31'd0, req1_accepted}, {31'd0, (i % 2 == 1)});
            tick();
            check($sformatf("rr%0d.done0", i), {31'd0, req0_done}, {31'd0, (i % 2 == 0)});
            check($sformatf("rr%0d.done1", i), {31'd0, req1_done}, {31'd0, (i % 2 == 1)});
            check($sformatf("rr%0d.rd", i), req0_rd, (i % 2 == 0) ? 32'd13 : 32'd300);
            if (i == 5) begin
                req0_order = 1'b0;
                req1_order = 1'b0;
            end
            tick();
        end

        // ---- FPU stalls accept for 3 cycles, finishes 4 cycles after accept
        fpu_auto = 1'b0;
        req0_order = 1'b1; req0_rs1 = 32'd5; req0_rs2 = 32'd7; req0_func3 = 3'b010;
        tick();
        check("stall.acc0", {31'd0, req0_accepted}, 32'd1);
        check("stall.order_c1", {31'd0, fpu_order}, 32'd1);
        req0_order = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("stall.order_c%0d", k + 2), {31'd0, fpu_order}, 32'd1);
            check($sformatf("stall.rs1_c%0d", k + 2), fpu_rs1, 32'd5);
            check($sformatf("stall.rs2_c%0d", k + 2), fpu_rs2, 32'd7);
            check($sformatf("stall.f3_c%0d", k + 2), {29'd0, fpu_func3}, 32'd2);
        end
        man_acc = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            man_acc = 1'b0;
            check($sformatf("wait.order_c%0d", k + 5), {31'd0, fpu_order}, 32'd0);
            check($sformatf("wait.done0_c%0d", k + 5), {31'd0, req0_done}, 32'd0);
        end
        man_done = 1'b1;
        tick();
        man_done = 1'b0;
        check("wait.done0", {31'd0, req0_done}, 32'd1);
        check("wait.rd0", req0_rd, 32'd12);
        tick();
        check("wait.done0_pulse", {31'd0, req0_done}, 32'd0);

        // ---- reset while waiting, then a late fpu_done
        req0_order = 1'b1; req0_rs1 = 32'h100; req0_rs2 = 32'h1; req0_func3 = 3'b000;
        tick();
        check("abort.acc0", {31'd0, req0_accepted}, 32'd1);
        req0_order = 1'b0;
        man_acc = 1'b1;
        tick();
        man_acc = 1'b0;
        check("abort.in_wait", {31'd0, fpu_order}, 32'd0);
        rst = 1'b1;
        tick();
        check_all_zero("abort.reset");
        rst = 1'b0;
        man_done = 1'b1;
        tick();
        man_done = 1'b0;
        check_all_zero("abort.late_done");

        // ---- prio back to 0 after reset; latched operands survive input change
        req0_order = 1'b1; req0_rs1 = 32'd1;    req0_rs2 = 32'd2;    req0_func3 = 3'b000;
        req1_order = 1'b1; req1_rs1 = 32'h11;   req1_rs2 = 32'h22;   req1_func3 = 3'b000;
        man_acc = 1'b1; man_done = 1'b1;
        tick();
        check("post.acc0", {31'd0, req0_accepted}, 32'd1);
        check("post.acc1", {31'd0, req1_accepted}, 32'd0);
        req0_order = 1'b0;
        tick();
        check("post.done0", {31'd0, req0_done}, 32'd1);
        check("post.rd0", req0_rd, 32'd3);
        man_acc = 1'b0; man_done = 1'b0;
        tick();
        tick();
        check("latch.acc1", {31'd0, req1_accepted}, 32'd1);
        check("latch.rs1_at_accept", fpu_rs1, 32'h11);
        req1_rs1 = 32'hFFFF; req1_rs2 = 32'hFFFF; req1_func3 = 3'b001;
        req1_order = 1'b0;
        tick();
        check("latch.order", {31'd0, fpu_order}, 32'd1);
        check("latch.rs1", fpu_rs1, 32'h11);
        check("latch.rs2", fpu_rs2, 32'h22);
        check("latch.f3", {29'd0, fpu_func3}, 32'd0);
        man_acc = 1'b1;
        tick();
        man_acc = 1'b0;
        man_done = 1'b1;
        tick();
        man_done = 1'b0;
        check("latch.done1", {31'd0, req1_done}, 32'd1);
        check("latch.done0_not", {31'd0, req0_done}, 32'd0);
        check("latch.rd1", req1_rd, 32'h33);
        check("latch.rd0_shared", req0_rd, 32'h33);
        tick();
        check("latch.done1_pulse", {31'd0, req1_done}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
